sdram_req_arb: RTL
==================

SDRAM_REQ_ARB -- requirements
Module: sdram_req_arb

Interface
REQ-001 Parameters: none; requester count fixed at 3 (index 0..2).
REQ-002 clk  in  1  system/SDRAM clock; single clock domain.
REQ-003 init_n  in  1  reset; synchronous, active-low.
REQ-004 rN_req  in  1  (N=0..2) level request; held until rN_ack.
REQ-005 rN_we  in  1  1=write, 0=read; valid while rN_req.
REQ-006 rN_a  in  23  word address [23:1]; valid while rN_req.
REQ-007 rN_ds  in  2  byte strobes {hi,lo}; valid while rN_req.
REQ-008 rN_d  in  16  write data; valid while rN_req.
REQ-009 rN_ack  out  1  one-cycle completion pulse.
REQ-010 rN_q  out  16  read data; valid on the rN_ack cycle, held until that requester's next ack.
REQ-011 mem_req  out  1  toggle request to the SDRAM controller port.
REQ-012 mem_ack  in  1  controller ack; transaction done when mem_ack == mem_req.
REQ-013 mem_we, mem_a[23:1], mem_ds[1:0], mem_d[15:0]  out  command fields; stable from issue until completion.
REQ-014 mem_q  in  16  read data; valid when mem_ack == mem_req.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 grant  out  2  index of the current or last served requester.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE: if any rN_req is high, the block latches the winner's we/a/ds/d into mem_* and its index into grant, then goes to ISSUE; otherwise it stays in IDLE.
REQ-019 Priority: r0 is absolute highest.
REQ-020 r1 and r2 share a round-robin pointer. When both request, the one not served last wins. The pointer updates only on grants to r1 or r2; after reset it favours r1.
REQ-021 ISSUE: mem_req toggles; the FSM goes to WAIT. Exactly one toggle per transaction.
REQ-022 WAIT: when mem_ack == mem_req, the block captures mem_q into rgrant_q (reads only; writes leave rN_q unchanged) and goes to DONE. Otherwise it stays in WAIT with no timeout.
REQ-023 DONE: rgrant_ack = 1 for exactly one cycle; the FSM returns to IDLE.
REQ-024 Requester rule: a requester clears rN_req on the clock edge at which it samples rN_ack = 1. If rN_req is still high in the following IDLE cycle, it is a new back-to-back transaction.
REQ-025 Latency: with the request present in IDLE at cycle 0, mem_req toggles at the end of cycle 1. rN_ack rises one cycle after the cycle in which mem_ack matches.
REQ-026 Requests arriving during ISSUE/WAIT/DONE stay pending and are arbitrated at the next IDLE. Losing requesters never receive ack.
REQ-027 At most one transaction is outstanding; mem_* fields do not change outside IDLE.
REQ-028 rN_ack outputs are mutually exclusive.

Reset
REQ-029 When init_n = 0 at a clock edge:
- state = IDLE; all rN_ack = 0; all rN_q = 0.
- busy = 0; grant = 0; round-robin pointer favours r1.
- mem_we = 0; mem_a = 0; mem_ds = 0; mem_d = 0.
REQ-030 During reset, mem_req loads the sampled mem_ack, so no transaction is left pending at the controller.
REQ-031 Reset mid-transaction abandons the transaction with no ack to any requester. The first IDLE after release re-arbitrates.

Structure
REQ-032 Package sdram_req_arb_pkg holds the FSM state enum and the requester-index constants (REQ_DL = 0, REQ_CPU = 1, REQ_VID = 2).
REQ-033 Sub-module sdram_req_arb_pick implements the combinational priority and round-robin winner selection (inputs: req vector, pointer; output: index, valid). All state stays in sdram_req_arb.

Verification
REQ-034 Single read: r1 reads a = 23'h000100; mem_ack follows mem_req after 6 cycles with mem_q = 16'hBEEF. Required: one toggle, r1_ack pulses once, r1_q = 16'hBEEF, busy low afterwards.
REQ-035 Priority: r0, r1 and r2 rise in the same cycle. Required grant order 0, 1, 2; no double ack.
REQ-036 Round-robin: r1 and r2 both held with back-to-back requests for 4 transactions. Required grant order 1, 2, 1, 2.
REQ-037 Write: r2 writes a = 23'h7FFFFF, ds = 2'b01, d = 16'h1234. Required: mem fields match and stay stable through WAIT; r2_q unchanged; r2_ack pulses.
REQ-038 Reset mid-WAIT: assert init_n = 0 while waiting, with mem_ack = 1. Required after reset: mem_req = 1, no ack, state IDLE, next request toggles mem_req to 0.

Source files
------------

// File: rtl/sdram_req_arb_pkg.sv
// Shared types and constants for the SDRAM request arbiter.
package sdram_req_arb_pkg;

    // Transaction sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Requester indices: downloader, CPU, video.
    localparam logic [1:0] REQ_DL  = 2'd0;
    localparam logic [1:0] REQ_CPU = 2'd1;
    localparam logic [1:0] REQ_VID = 2'd2;

endpackage

// File: rtl/sdram_req_arb_pick.sv
// Winner selection: r0 has absolute priority, r1/r2 share a round-robin
// pointer supplied by the parent. Purely combinational.
module sdram_req_arb_pick
    import sdram_req_arb_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic       rr_vid_i,   // 1: r2 wins an r1/r2 tie, 0: r1 wins
    output logic [1:0] idx_o,
    output logic       valid_o
);

    // Fixed priority for r0, pointer-based tie break between r1 and r2.
    always_comb begin
        idx_o   = REQ_DL;
        valid_o = 1'b1;
        if (req_i[0]) begin
            idx_o = REQ_DL;
        end else if (req_i[1] && req_i[2]) begin
            idx_o = rr_vid_i ? REQ_VID : REQ_CPU;
        end else if (req_i[1]) begin
            idx_o = REQ_CPU;
        end else if (req_i[2]) begin
            idx_o = REQ_VID;
        end else begin
            valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/sdram_req_arb.sv
// Three-port request arbiter in front of a toggle-handshake SDRAM controller.
// One transaction outstanding at a time; command fields held from issue to
// completion.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | arbitrate; latch winner's command fields and index
// ST_ISSUE | toggle mem_req once
// ST_WAIT  | wait for mem_ack == mem_req; capture read data
// ST_DONE  | one-cycle ack pulse to the served requester
module sdram_req_arb
    import sdram_req_arb_pkg::*;
(
    input  logic        clk,
    input  logic        init_n,

    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [23:1] r0_a,
    input  logic [1:0]  r0_ds,
    input  logic [15:0] r0_d,
    output logic        r0_ack,
    output logic [15:0] r0_q,

    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [23:1] r1_a,
    input  logic [1:0]  r1_ds,
    input  logic [15:0] r1_d,
    output logic        r1_ack,
    output logic [15:0] r1_q,

    input  logic        r2_req,
    input  logic        r2_we,
    input  logic [23:1] r2_a,
    input  logic [1:0]  r2_ds,
    input  logic [15:0] r2_d,
    output logic        r2_ack,
    output logic [15:0] r2_q,

    output logic        mem_req,
    input  logic        mem_ack,
    output logic        mem_we,
    output logic [23:1] mem_a,
    output logic [1:0]  mem_ds,
    output logic [15:0] mem_d,
    input  logic [15:0] mem_q,

    output logic        busy,
    output logic [1:0]  grant
);

    state_e      state_q;
    logic [2:0]  ack_q;
    logic [15:0] r0_q_q, r1_q_q, r2_q_q;
    logic [1:0]  grant_q;
    logic        rr_vid_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [23:1] mem_a_q;
    logic [1:0]  mem_ds_q;
    logic [15:0] mem_d_q;

    logic [1:0]  pick_idx;
    logic        pick_valid;
    logic        sel_we;
    logic [23:1] sel_a;
    logic [1:0]  sel_ds;
    logic [15:0] sel_d;

    sdram_req_arb_pick u_pick (
        .req_i    ({r2_req, r1_req, r0_req}),
        .rr_vid_i (rr_vid_q),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    // Route the winning requester's command fields toward the latch.
    always_comb begin
        sel_we = r0_we;
        sel_a  = r0_a;
        sel_ds = r0_ds;
        sel_d  = r0_d;
        case (pick_idx)
            REQ_CPU: begin
                sel_we = r1_we;
                sel_a  = r1_a;
                sel_ds = r1_ds;
                sel_d  = r1_d;
            end
            REQ_VID: begin
                sel_we = r2_we;
                sel_a  = r2_a;
                sel_ds = r2_ds;
                sel_d  = r2_d;
            end
            default: ;
        endcase
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            state_q   <= ST_IDLE;
            ack_q     <= '0;
            r0_q_q    <= '0;
            r1_q_q    <= '0;
            r2_q_q    <= '0;
            grant_q   <= REQ_DL;
            rr_vid_q  <= 1'b0;
            // Track the controller so nothing is left pending across reset.
            mem_req_q <= mem_ack;
            mem_we_q  <= 1'b0;
            mem_a_q   <= '0;
            mem_ds_q  <= '0;
            mem_d_q   <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q  <= pick_idx;
                        mem_we_q <= sel_we;
                        mem_a_q  <= sel_a;
                        mem_ds_q <= sel_ds;
                        mem_d_q  <= sel_d;
                        if (pick_idx == REQ_CPU) begin
                            rr_vid_q <= 1'b1;
                        end else if (pick_idx == REQ_VID) begin
                            rr_vid_q <= 1'b0;
                        end
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_req_q <= ~mem_req_q;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_ack == mem_req_q) begin
                        case (grant_q)
                            REQ_DL: begin
                                ack_q[0] <= 1'b1;
                                if (!mem_we_q) r0_q_q <= mem_q;
                            end
                            REQ_CPU: begin
                                ack_q[1] <= 1'b1;
                                if (!mem_we_q) r1_q_q <= mem_q;
                            end
                            default: begin
                                ack_q[2] <= 1'b1;
                                if (!mem_we_q) r2_q_q <= mem_q;
                            end
                        endcase
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign r0_ack  = ack_q[0];
    assign r1_ack  = ack_q[1];
    assign r2_ack  = ack_q[2];
    assign r0_q    = r0_q_q;
    assign r1_q    = r1_q_q;
    assign r2_q    = r2_q_q;
    assign mem_req = mem_req_q;
    assign mem_we  = mem_we_q;
    assign mem_a   = mem_a_q;
    assign mem_ds  = mem_ds_q;
    assign mem_d   = mem_d_q;
    assign busy    = (state_q != ST_IDLE);
    assign grant   = grant_q;

endmodule
